// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 frames LSB first, with level, busy and sticky overflow status.
// Optional feature macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits (8E1 frames).
module uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       busy,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic [CW-1:0] BAUD_ZER = CW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [4:0]    DEPTH_C  = 5'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic [4:0]    w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          w_push;
  logic          w_pop;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [CW-1:0] w_baud_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          r_busy;
  logic          w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
  logic          w_par_nxt;
`endif

  // Writes are judged on the registered full flag, so a pop in the same cycle cannot rescue them.
  assign w_push    = wr & ~r_full;
  assign w_bit_end = (r_baud == BAUD_ZER);

  // Transmit FSM next-state, baud/bit counters, shift register and pop request.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud - BAUD_ONE;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = DIV_M1;
        w_bit_nxt  = 3'd0;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = even_par(r_mem[r_rptr]);
`endif
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = DIV_M1;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = DIV_M1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_nxt  = DIV_M1;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = DIV_M1;
          w_bit_nxt  = 3'd0;
          // A queued byte starts on the same edge, so back-to-back frames have no idle gap.
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = even_par(r_mem[r_rptr]);
`endif
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_baud_nxt  = DIV_M1;
        w_bit_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state so tx is a plain flop.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      S_STOP:   w_tx_nxt = 1'b1;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 5'd1;
      2'b01:   w_count_nxt = r_count - 5'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Transmit FSM registers, registered line output and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= DIV_M1;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the byte being sent, captured when it leaves the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  // FIFO pointers and registered level flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= 5'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == 5'd0);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Sticky overflow flag; a dropped write wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (wr && r_full) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign tx    = r_tx;
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;
  assign busy  = r_busy;
  assign ovf   = r_ovf;

endmodule
